// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that turns a valid/ready byte stream into
// 16-bit instruction words and writes them to instruction memory from
// address 0. The CPU is held (cpu_run low) until the image is complete.
// Stream: length N (high byte first), N words (high byte first), then an
// optional checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int IW     = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reload,
  output logic              im_wen,
  output logic [ADDR_W-1:0] im_addr,
  output logic [IW-1:0]     im_wdata,
  output logic              cpu_run,
  output logic              done,
  output logic              err,
  output logic [15:0]       word_cnt
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {LEN_HI, LEN_LO, W_HI, W_LO, CHK, DONE, ERROR} state_t;
  localparam state_t END_ST = CHK;
`else
  typedef enum logic [2:0] {LEN_HI, LEN_LO, W_HI, W_LO, DONE, ERROR} state_t;
  localparam state_t END_ST = DONE;
`endif

  // Largest legal image: exactly fills the memory, no wrap.
  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

  state_t state_q, state_d;

  logic [15:0]       len_q, len_d;
  logic [7:0]        hi_q, hi_d;
  logic [15:0]       cnt_d;
  logic              wen_d;
  logic [ADDR_W-1:0] addr_d;
  logic [IW-1:0]     wdata_d;
  logic              accept;
  logic              receiving;
  logic [15:0]       len_word;
  logic              last_word;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        chk_q, chk_d;
`endif

  assign receiving = (state_q != DONE) && (state_q != ERROR);
  assign in_ready  = rst && receiving;
  assign accept    = in_valid && in_ready;
  assign len_word  = {len_q[15:8], in_data};
  assign last_word = ((word_cnt + 16'd1) == len_q);

  // Next-state and next-register values; every byte moves the FSM on accept only.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    hi_d    = hi_q;
    cnt_d   = word_cnt;
    wen_d   = 1'b0;
    addr_d  = im_addr;
    wdata_d = im_wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk_d   = chk_q;
    if (accept && (state_q != CHK)) begin
      chk_d = chk_q ^ in_data;
    end
`endif
    case (state_q)
      LEN_HI: begin
        if (accept) begin
          len_d   = {in_data, 8'h00};
          state_d = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_d = len_word;
          if ({1'b0, len_word} > MAX_WORDS) begin
            state_d = ERROR;
          end else if (len_word == 16'd0) begin
            state_d = END_ST;
          end else begin
            state_d = W_HI;
          end
        end
      end
      W_HI: begin
        if (accept) begin
          hi_d    = in_data;
          state_d = W_LO;
        end
      end
      W_LO: begin
        if (accept) begin
          wen_d   = 1'b1;
          addr_d  = word_cnt[ADDR_W-1:0];
          wdata_d = IW'({hi_q, in_data});
          cnt_d   = word_cnt + 16'd1;
          state_d = last_word ? END_ST : W_HI;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        if (accept) begin
          state_d = ((chk_q ^ in_data) == 8'h00) ? DONE : ERROR;
        end
      end
`endif
      DONE, ERROR: begin
        if (reload) begin
          state_d = LEN_HI;
          cnt_d   = 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_d   = 8'h00;
`endif
        end
      end
      default: begin
        state_d = LEN_HI;
      end
    endcase
  end

  // State and registered outputs; status flags follow the state being entered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= LEN_HI;
      len_q    <= 16'd0;
      hi_q     <= 8'h00;
      word_cnt <= 16'd0;
      im_wen   <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
      cpu_run  <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      hi_q     <= hi_d;
      word_cnt <= cnt_d;
      im_wen   <= wen_d;
      im_addr  <= addr_d;
      im_wdata <= wdata_d;
      cpu_run  <= (state_d == DONE);
      done     <= (state_d == DONE);
      err      <= (state_d == ERROR);
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running XOR of every image byte, cleared on reset and on reload.
  always_ff @(posedge clk) begin
    if (!rst) begin
      chk_q <= 8'h00;
    end else begin
      chk_q <= chk_d;
    end
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader.
// The reference model works on byte positions inside the stream and
// predicts each write, the final status and the word count per cycle.
module tb_imem_loader;
  localparam int ADDR_W    = 8;
  localparam int IW        = 16;
  localparam int MAX_WORDS = 1 << ADDR_W;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  typedef logic [7:0]  bq_t[$];
  typedef logic [15:0] wq_t[$];

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              reload;
  logic              im_wen;
  logic [ADDR_W-1:0] im_addr;
  logic [IW-1:0]     im_wdata;
  logic              cpu_run;
  logic              done;
  logic              err;
  logic [15:0]       word_cnt;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  imem_loader #(.IW(IW), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .reload   (reload),
    .im_wen   (im_wen),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .cpu_run  (cpu_run),
    .done     (done),
    .err      (err),
    .word_cnt (word_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic wq_t randomWords(input int n);
    wq_t w;
    for (int j = 0; j < n; j++) w.push_back(16'($urandom));
    return w;
  endfunction

  function automatic bq_t makeStream(input int n, input wq_t words, input bit badChk);
    bq_t s;
    logic [15:0] len;
    logic [7:0] x;
    len = 16'(n);
    s.push_back(len[15:8]);
    s.push_back(len[7:0]);
    if (n <= MAX_WORDS) begin
      for (int j = 0; j < n; j++) begin
        s.push_back(words[j][15:8]);
        s.push_back(words[j][7:0]);
      end
      if (CHK_EN) begin
        x = 8'h00;
        foreach (s[i]) x = x ^ s[i];
        s.push_back(badChk ? (x ^ 8'h5A) : x);
      end
    end
    return s;
  endfunction

  // Drive a whole stream (mode 0 always valid, 1 every other cycle, 2 random)
  // and check every cycle against the byte-position model.
  task automatic applyStimulus(input bq_t s, input int mode);
    int n, last, idx, nWrites, extra, budget, pendAddr, cyc;
    bit overflow, finalOk, finished, pendWr, drive;
    logic [15:0] pendData;
    logic [7:0] x;
    logic [3:0] expStatus;
    n        = int'({s[0], s[1]});
    overflow = (n > MAX_WORDS);
    if (overflow) begin
      last = 1; finalOk = 1'b0;
    end else if (CHK_EN) begin
      last = 2 * n + 2;
      x = 8'h00;
      foreach (s[i]) x = x ^ s[i];
      finalOk = (x == 8'h00);
    end else begin
      last = (n == 0) ? 1 : 2 * n + 1;
      finalOk = 1'b1;
    end
    idx = 0; nWrites = 0; extra = 0; finished = 1'b0; pendWr = 1'b0;
    pendAddr = 0; pendData = 16'h0;
    budget = 8 * s.size() + 40;
    for (cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      checkOutput("wen", 32'(im_wen), 32'(pendWr));
      if (pendWr) begin
        checkOutput("addr", 32'(im_addr), 32'(pendAddr));
        checkOutput("data", 32'(im_wdata), 32'(pendData));
      end
      expStatus = finished ? (finalOk ? 4'b1100 : 4'b0010) : 4'b0001;
      checkOutput("status run/done/err/ready", 32'({cpu_run, done, err, in_ready}), 32'(expStatus));
      checkOutput("word_cnt", 32'(word_cnt), 32'(nWrites));
      if (finished && extra >= 3) break;
      if (finished) extra++;
      if (!finished) begin
        case (mode)
          0:       drive = 1'b1;
          1:       drive = (cyc % 2 == 0);
          default: drive = ($urandom_range(0, 99) < 70);
        endcase
        in_valid = drive;
        in_data  = drive ? s[idx] : 8'($urandom);
      end else begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 8'($urandom);
      end
      pendWr = 1'b0;
      if (in_valid && !finished) begin
        if (!overflow && idx >= 3 && idx <= 2 * n + 1 && (idx % 2) == 1) begin
          pendWr   = 1'b1;
          pendAddr = (idx - 3) / 2;
          pendData = {s[idx - 1], s[idx]};
          nWrites++;
        end
        if (idx == last) finished = 1'b1;
        idx++;
      end
    end
    in_valid = 1'b0;
    checkOutput("stream_end", 32'(finished && extra >= 3), 32'd1);
  endtask

  // Reload pulse from DONE/ERROR, optionally with a competing byte.
  task automatic doReload(input bit withByte);
    @(negedge clk);
    reload   = 1'b1;
    in_valid = withByte;
    in_data  = 8'($urandom);
    checkOutput("ready_in_final", 32'(in_ready), 32'd0);
    @(negedge clk);
    reload   = 1'b0;
    in_valid = 1'b0;
    checkOutput("after_reload run/done/err/ready", 32'({cpu_run, done, err, in_ready}), 32'(4'b0001));
    checkOutput("reload_word_cnt", 32'(word_cnt), 32'd0);
  endtask

  task automatic doReset(input int cycles);
    @(negedge clk);
    rst      = 1'b0;
    reload   = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    repeat (cycles) begin
      @(negedge clk);
      checkOutput("reset_ready", 32'(in_ready), 32'd0);
      checkOutput("reset_outs", 32'({im_wen, cpu_run, done, err, im_addr, im_wdata}), 32'd0);
      checkOutput("reset_word_cnt", 32'(word_cnt), 32'd0);
    end
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("release_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic sendPartial(input bq_t s, input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = s[i];
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    wq_t w;
    bq_t s;
    int n;
    rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; reload = 1'b0;
    doReset(3);

    w = {16'h1234, 16'hABCD};
    s = makeStream(2, w, 1'b0);
    applyStimulus(s, 0);
    doReload(1'b1);
    applyStimulus(s, 1);
    doReload(1'b0);

    w.delete();
    s = makeStream(0, w, 1'b0);
    applyStimulus(s, 0);
    doReload(1'b1);

    s = makeStream(16'h0101, w, 1'b0);
    applyStimulus(s, 0);
    doReload(1'b1);

    w = randomWords(MAX_WORDS);
    s = makeStream(MAX_WORDS, w, 1'b0);
    applyStimulus(s, 2);
    doReload(1'b0);

    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(1, 20);
      w = randomWords(n);
      s = makeStream(n, w, CHK_EN && (t % 3 == 2));
      applyStimulus(s, 2);
      doReload(1'(t % 2));
    end

    w = {16'h1234, 16'hABCD};
    s = makeStream(2, w, 1'b0);
    sendPartial(s, 3);
    doReset(2);
    applyStimulus(s, 0);
    doReload(1'b0);

    w = randomWords(3);
    s = makeStream(3, w, 1'b0);
    sendPartial(s, 5);
    doReset(2);
    applyStimulus(s, 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
